// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath.
//   - aes_state_t / aes_byte_t : 128-bit state block and single byte types
//   - isb_state_e              : control states of the InvSubBytes sequencer
//   - get_byte / set_byte      : FIPS-197 byte addressing, byte i = s[127-8i -: 8]
//   - inv_shift_rows           : work[r+4c] = in[r+4((c-r) mod 4)]
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } isb_state_e;

    function automatic aes_byte_t get_byte(input aes_state_t s, input int i);
        return s[127 - 8*i -: 8];
    endfunction

    function automatic aes_state_t set_byte(input aes_state_t s, input int i, input aes_byte_t b);
        aes_state_t r;
        r = s;
        r[127 - 8*i -: 8] = b;
        return r;
    endfunction

    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t r;
        r = s;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                // +4 keeps the modulo operand non-negative
                r = set_byte(r, rw + 4*c, get_byte(s, rw + 4*((c - rw + 4) % 4)));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready stream carrying one 128-bit AES state block.
//   valid : source holds a block
//   ready : sink accepts the block this cycle
//   data  : state block, FIPS-197 column-major byte order
// master = source side, slave = sink side.
interface inv_sub_bytes_seq_if;
    import aes_pkg::*;

    logic       valid;
    logic       ready;
    aes_state_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/inv_sub_bytes_seq_lut.sv
// Module inv_sbox_lut: combinational FIPS-197 inverse S-box.
//   in_byte  : input byte
//   out_byte : inv_sbox(in_byte)
// The table is stored as 16 rows selected by the high nibble; the low nibble
// picks the byte within the row (leftmost byte = column 0).
module inv_sbox_lut
    import aes_pkg::*;
(
    input  aes_byte_t in_byte,
    output aes_byte_t out_byte
);

    logic [127:0] row_s;

    // Row select on the high nibble
    always_comb begin
        row_s = 128'h0;
        case (in_byte[7:4])
            4'h0: row_s = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row_s = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row_s = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row_s = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row_s = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row_s = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row_s = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row_s = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row_s = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row_s = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row_s = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row_s = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row_s = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row_s = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row_s = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            4'hf: row_s = 128'h172b047eba77d626e169146355210c7d;
            default: row_s = 128'h0;
        endcase
    end

    // Column c sits at bits 127-8c; {~c,3'b111} computes that top bit index
    assign out_byte = row_s[{~in_byte[3:0], 3'b111} -: 8];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes stage.
// Accepts a 128-bit state on in_if, substitutes LANES bytes per cycle through
// inverse S-boxes, and presents the result on out_if until it is taken.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset (aborts any block in progress)
//   in_if  : slave stream, in_if.ready depends only on state (high in IDLE)
//   out_if : master stream, out_if.valid high in DONE, out_if.data = last result
//   busy   : high in SUB or DONE
// Parameter LANES: 1, 2, 4, 8 or 16 bytes per cycle.
// Optional build macro ISB_INV_SHIFT_ROWS_EN: apply InvShiftRows at capture.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    inv_sub_bytes_seq_if.slave         in_if,
    inv_sub_bytes_seq_if.master        out_if,
    output logic                       busy
);

    localparam int NCHUNK = AES_BLOCK_BYTES / LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    isb_state_e   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    aes_state_t   work_q, work_d;
    aes_state_t   out_data_q, out_data_d;
    aes_state_t   capture_s;
    aes_byte_t    lut_in  [LANES];
    aes_byte_t    lut_out [LANES];

`ifdef ISB_INV_SHIFT_ROWS_EN
    assign capture_s = inv_shift_rows(in_if.data);
`else
    assign capture_s = in_if.data;
`endif

    // Route the bytes of the current chunk to the lane S-boxes
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lut_in[l] = get_byte(work_q, int'(count_q) * LANES + l);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_sbox_lut u_lut (
            .in_byte  (lut_in[g]),
            .out_byte (lut_out[g])
        );
    end

    // Next-state, counter and datapath update
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        work_d     = work_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_if.valid) begin
                    work_d  = capture_s;
                    count_d = {CW{1'b0}};
                    state_d = SUB;
                end else begin
                    state_d = IDLE;
                end
            end
            SUB: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d = set_byte(work_d, int'(count_q) * LANES + l, lut_out[l]);
                end
                if (count_q == LAST) begin
                    // Result register changes only on entry to DONE so it
                    // survives the next capture into the work register
                    out_data_d = work_d;
                    state_d    = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            DONE: begin
                if (out_if.ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, work and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= {CW{1'b0}};
            work_q     <= 128'h0;
            out_data_q <= 128'h0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            work_q     <= work_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_if.ready  = (state_q == IDLE);
    assign out_if.valid = (state_q == DONE);
    assign out_if.data  = out_data_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: main instance with LANES=4 plus four small
// instances (LANES 1,2,8,16) for the latency sweep. Expected results come from
// an inverse S-box table derived from GF(2^8) arithmetic at time zero.
module tb_inv_sub_bytes_seq;
    import aes_pkg::*;

    localparam int LANES  = 4;
    localparam int NCHUNK = 16 / LANES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   failures = 0;

    aes_byte_t  inv_tab [256];
    aes_state_t exp_q [$];

    inv_sub_bytes_seq_if in_if ();
    inv_sub_bytes_seq_if out_if ();

    inv_sub_bytes_seq #(.LANES(LANES)) dut (
        .clk    (clk),
        .rst    (rst),
        .in_if  (in_if.slave),
        .out_if (out_if.master),
        .busy   (busy)
    );

    // Sweep instances share one input stream and always accept output
    logic       sw_valid = 1'b0;
    aes_state_t sw_data  = 128'h0;
    logic [3:0] sw_ov;
    aes_state_t sw_od [4];

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        inv_sub_bytes_seq_if sin ();
        inv_sub_bytes_seq_if sout ();
        logic b;
        assign sin.valid  = sw_valid;
        assign sin.data   = sw_data;
        assign sout.ready = 1'b1;
        assign sw_ov[g]   = sout.valid;
        assign sw_od[g]   = sout.data;
        inv_sub_bytes_seq #(.LANES(L)) u_sw (
            .clk    (clk),
            .rst    (rst),
            .in_if  (sin.slave),
            .out_if (sout.master),
            .busy   (b)
        );
    end

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] v = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(a, 8'(c)) == 8'h01) v = 8'(c);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic aes_state_t model(input aes_state_t din);
        aes_state_t s;
        aes_state_t r;
`ifdef ISB_INV_SHIFT_ROWS_EN
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                int src;
                src = rw + 4 * ((c + 4 - rw) % 4);
                s[127 - 8*(rw + 4*c) -: 8] = din[127 - 8*src -: 8];
            end
        end
`else
        s = din;
`endif
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = inv_tab[s[127 - 8*i -: 8]];
        end
        return r;
    endfunction

    function automatic aes_state_t rnd_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a block until it is taken; optionally record its expected result
    task automatic send(input aes_state_t d, input bit push);
        int waited = 0;
        in_if.valid = 1'b1;
        in_if.data  = d;
        while (!in_if.ready && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (in_if.ready) begin
            tick();
            if (push) exp_q.push_back(model(d));
        end else begin
            failures++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_if.ready, waited);
        end
        in_if.valid = 1'b0;
        in_if.data  = rnd_block();
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_if.valid && cyc < 100) begin
            tick();
            cyc++;
        end
        checks++;
        if (!out_if.valid) begin
            failures++;
            $display("FAIL out_valid_timeout: out_valid=%0b after %0d cycles, required 1", out_if.valid, cyc);
        end
    endtask

    task automatic test_reset();
        int spurious = 0;
        rst = 1'b1;
        in_if.valid = 1'b0;
        in_if.data = 128'h0;
        out_if.ready = 1'b0;
        repeat (3) tick();
        checks += 4;
        if (out_if.valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b required 0", out_if.valid); end
        if (out_if.data !== 128'h0) begin failures++; $display("FAIL reset_out_data: got %h required 0", out_if.data); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", busy); end
        if (in_if.ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b required 1", in_if.ready); end
        rst = 1'b0;
        tick();
        send(rnd_block(), 1'b0);
        tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL mid_sub_busy: got %0b required 1", busy); end
        rst = 1'b1;
        repeat (3) tick();
        checks += 4;
        if (out_if.valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid: got %0b required 0", out_if.valid); end
        if (out_if.data !== 128'h0) begin failures++; $display("FAIL abort_out_data: got %h required 0", out_if.data); end
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %0b required 0", busy); end
        if (in_if.ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready: got %0b required 1", in_if.ready); end
        rst = 1'b0;
        out_if.ready = 1'b1;
        repeat (10) begin
            tick();
            if (out_if.valid) spurious++;
        end
        checks++;
        if (spurious != 0) begin failures++; $display("FAIL abort_spurious: %0d cycles with out_valid, required 0", spurious); end
    endtask

    task automatic test_known_vector();
        int lat;
        aes_state_t e;
        out_if.ready = 1'b1;
        send(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
        wait_valid(lat);
        checks += 3;
        if (lat != NCHUNK) begin failures++; $display("FAIL known_latency: got %0d required %0d", lat, NCHUNK); end
`ifdef ISB_INV_SHIFT_ROWS_EN
        e = 128'h52f3a3383009d79ebf366afb8140a5d5;
`else
        e = 128'h52096ad53036a538bf40a39e81f3d7fb;
`endif
        if (out_if.data !== e) begin failures++; $display("FAIL known_vector: got %h required %h", out_if.data, e); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        if (out_if.data !== e) begin failures++; $display("FAIL known_scoreboard: got %h required %h", out_if.data, e); end
        tick();
        checks++;
        if (in_if.ready !== 1'b1) begin failures++; $display("FAIL known_idle: in_ready=%0b required 1", in_if.ready); end
    endtask

    task automatic test_special_values();
        aes_byte_t vin [3];
        aes_byte_t vout [3];
        int lat;
        aes_state_t e;
        vin[0] = 8'h63; vout[0] = 8'h00;
        vin[1] = 8'hff; vout[1] = 8'h7d;
        vin[2] = 8'h00; vout[2] = 8'h52;
        out_if.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send({16{vin[k]}}, 1'b1);
            wait_valid(lat);
            checks += 2;
            if (out_if.data !== {16{vout[k]}}) begin failures++; $display("FAIL special_%h: got %h required %h", vin[k], out_if.data, {16{vout[k]}}); end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
            if (out_if.data !== e) begin failures++; $display("FAIL special_scoreboard: got %h required %h", out_if.data, e); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        aes_state_t held;
        aes_state_t e;
        out_if.ready = 1'b0;
        send(rnd_block(), 1'b1);
        wait_valid(lat);
        held = out_if.data;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        checks++;
        if (held !== e) begin failures++; $display("FAIL bp_scoreboard: got %h required %h", held, e); end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (out_if.valid !== 1'b1 || out_if.data !== e || in_if.ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: valid=%0b data=%h in_ready=%0b required 1/%h/0", c, out_if.valid, out_if.data, in_if.ready, e);
            end
        end
        out_if.ready = 1'b1;
        tick();
        out_if.ready = 1'b0;
        checks += 3;
        if (out_if.valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %0b required 0", out_if.valid); end
        if (in_if.ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %0b required 1", in_if.ready); end
        if (out_if.data !== e) begin failures++; $display("FAIL bp_keep_data: got %h required %h", out_if.data, e); end
    endtask

    task automatic test_random_stall();
        aes_state_t e;
        for (int n = 0; n < 6; n++) begin
            bit done = 1'b0;
            int guard = 0;
            send(rnd_block(), 1'b1);
            while (!done && guard < 200) begin
                if (out_if.valid) begin
                    out_if.ready = 1'($urandom_range(0, 1));
                    if (out_if.ready) begin
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                        checks++;
                        if (out_if.data !== e) begin failures++; $display("FAIL stall_scoreboard %0d: got %h required %h", n, out_if.data, e); end
                        done = 1'b1;
                    end
                end
                tick();
                guard++;
            end
            out_if.ready = 1'b0;
            if (!done) begin
                checks++;
                failures++;
                $display("FAIL stall_timeout %0d: no transfer within %0d cycles", n, guard);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        aes_state_t d;
        aes_state_t e;
        int guard = 0;
        out_if.ready = 1'b1;
        in_if.valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            d = rnd_block();
            in_if.data = d;
            if (in_if.ready) begin
                exp_q.push_back(model(d));
                acc.push_back(cyc);
            end
            tick();
            if (out_if.valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                checks++;
                if (out_if.data !== e) begin failures++; $display("FAIL b2b_scoreboard: got %h required %h", out_if.data, e); end
            end
        end
        in_if.valid = 1'b0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick();
            guard++;
            if (out_if.valid) begin
                e = exp_q.pop_front();
                checks++;
                if (out_if.data !== e) begin failures++; $display("FAIL b2b_drain: got %h required %h", out_if.data, e); end
            end
        end
        tick();
        checks++;
        if (exp_q.size() != 0 || acc.size() < 5) begin
            failures++;
            $display("FAIL b2b_count: pending=%0d accepted=%0d required 0 and >=5", exp_q.size(), acc.size());
        end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != NCHUNK + 2) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d required %0d", acc[i] - acc[i-1], NCHUNK + 2);
            end
        end
    endtask

    task automatic test_latency_sweep();
        int lat [4];
        int want [4];
        aes_state_t e;
        want[0] = 16; want[1] = 8; want[2] = 2; want[3] = 1;
        for (int k = 0; k < 4; k++) lat[k] = 0;
        sw_data = rnd_block();
        e = model(sw_data);
        sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (sw_ov[k] && lat[k] == 0) begin
                    lat[k] = c;
                    checks++;
                    if (sw_od[k] !== e) begin failures++; $display("FAIL sweep_data lanes=%0d: got %h required %h", 16 / want[k], sw_od[k], e); end
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lat[k] != want[k]) begin
                failures++;
                $display("FAIL sweep_latency lanes=%0d: got %0d required %0d", 16 / want[k], lat[k], want[k]);
            end
        end
    endtask

    initial begin
        in_if.valid = 1'b0;
        in_if.data = 128'h0;
        out_if.ready = 1'b0;
        for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);
        test_reset();
        test_known_vector();
        test_special_values();
        test_backpressure();
        test_random_stall();
        test_back_to_back();
        test_latency_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
